ksa_top: RTL and testbench

- Parameterised unsigned Kogge-Stone parallel-prefix adder. Computes s + carry-out = a + b + c0.
- Operands and carry-in are captured on the clock; the registered sum and carry-out are presented one cycle later.
- Used as the fast-add datapath primitive. The default 8-bit build is the verification target.

---
 rtl/ksa_pkg.sv | 22 ++
 rtl/ksa_prefix_cell.sv | 15 +
 rtl/ksa_top.sv | 104 ++++++++++
 tb/tb_ksa_top.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone adder: default width, prefix-level count
// and the (generate, propagate) pair carried through the prefix tree.
package ksa_pkg;

  localparam int KSA_WIDTH = 8;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Smallest n with 2^n >= width; widths are powers of two up to 64.
  function automatic int ksaStages(input int width);
    int n;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << i) < width) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone black cell: merges a high (G,P) group with the adjacent lower group.
// Used as a gray cell by leaving p unconnected at the consumer side.
module ksa_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/ksa_top.sv
// Registered Kogge-Stone adder: {c32, s} = a + b + c0, one cycle after in_valid.
// Prefix index j maps to bit position j-1, so index 0 carries c0 as position -1.
module ksa_top
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c32,
  output logic             out_valid
);

  localparam int STAGES = ksaStages(WIDTH);

  gp_t              seed [0:WIDTH];
  logic [WIDTH:0]   gLvl [0:STAGES];
  logic [WIDTH:0]   pLvl [0:STAGES];
  logic [WIDTH-1:0] sumComb;
  logic             coutComb;
  logic             unusedCoutP;
  logic             unusedP;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q;

  always_comb begin
    seed[0] = '{g: c0, p: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      seed[i+1] = '{g: a[i] & b[i], p: a[i] ^ b[i]};
    end
  end

  for (genvar j = 0; j <= WIDTH; j++) begin : gSeed
    assign gLvl[0][j] = seed[j].g;
    assign pLvl[0][j] = seed[j].p;
  end

  for (genvar k = 0; k < STAGES; k++) begin : gLevel
    for (genvar j = 0; j <= WIDTH; j++) begin : gPos
      if (j >= (1 << k)) begin : gCell
        ksa_prefix_cell uCell (
          .g_hi (gLvl[k][j]),
          .p_hi (pLvl[k][j]),
          .g_lo (gLvl[k][j-(1<<k)]),
          .p_lo (pLvl[k][j-(1<<k)]),
          .g    (gLvl[k+1][j]),
          .p    (pLvl[k+1][j])
        );
      end else begin : gPass
        assign gLvl[k+1][j] = gLvl[k][j];
        assign pLvl[k+1][j] = pLvl[k][j];
      end
    end
  end

  // After STAGES levels the top index spans [WIDTH:1]; one gray cell folds in c0.
  ksa_prefix_cell uCout (
    .g_hi (gLvl[STAGES][WIDTH]),
    .p_hi (pLvl[STAGES][WIDTH]),
    .g_lo (gLvl[STAGES][0]),
    .p_lo (pLvl[STAGES][0]),
    .g    (coutComb),
    .p    (unusedCoutP)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : gSum
    assign sumComb[i] = seed[i+1].p ^ gLvl[STAGES][i];
  end

  assign unusedP = ^{pLvl[STAGES], unusedCoutP};

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (in_valid) begin
      sum_d  = sumComb;
      cout_d = coutComb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= in_valid;
    end
  end

  assign s         = sum_q;
  assign c32       = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ksa_top.sv
// Self-checking bench for ksa_top: 8-bit and 16-bit builds side by side, checked
// against plain integer addition with a one-cycle, valid-gated reference.
module tb_ksa_top;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c0 = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  s;
  logic          c32;
  logic          out_valid;
  logic [W2-1:0] a2 = '0;
  logic [W2-1:0] b2 = '0;
  logic [W2-1:0] s2;
  logic          c32w;
  logic          outValid2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  expS  = '0;
  logic          expC  = 1'b0;
  logic          expV  = 1'b0;
  logic [W2-1:0] expS2 = '0;
  logic          expC2 = 1'b0;

  always #5 clk = ~clk;

  ksa_top #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c0        (c0),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s),
    .c32       (c32),
    .out_valid (out_valid)
  );

  ksa_top #(.WIDTH(W2)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .c0        (c0),
    .a         (a2),
    .b         (b2),
    .in_valid  (in_valid),
    .s         (s2),
    .c32       (c32w),
    .out_valid (outValid2)
  );

  task automatic checkOutput(input string tag);
    checks++;
    assert (s === expS) else begin
      errors++;
      $error("[TB] FAIL %s s: got %0h want %0h", tag, s, expS);
    end
    checks++;
    assert (c32 === expC) else begin
      errors++;
      $error("[TB] FAIL %s c32: got %0b want %0b", tag, c32, expC);
    end
    checks++;
    assert (out_valid === expV) else begin
      errors++;
      $error("[TB] FAIL %s out_valid: got %0b want %0b", tag, out_valid, expV);
    end
    checks++;
    assert (s2 === expS2) else begin
      errors++;
      $error("[TB] FAIL %s s16: got %0h want %0h", tag, s2, expS2);
    end
    checks++;
    assert (c32w === expC2) else begin
      errors++;
      $error("[TB] FAIL %s c16: got %0b want %0b", tag, c32w, expC2);
    end
    checks++;
    assert (outValid2 === expV) else begin
      errors++;
      $error("[TB] FAIL %s valid16: got %0b want %0b", tag, outValid2, expV);
    end
  endtask

  // Drives one cycle of input and advances the reference past the clock edge.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc, input logic tv);
    int unsigned full;
    int unsigned full2;
    a        = ta;
    b        = tb;
    c0       = tc;
    in_valid = tv;
    a2       = W2'($urandom);
    b2       = W2'($urandom);
    full     = int'(ta) + int'(tb) + int'(tc);
    full2    = int'(a2) + int'(b2) + int'(tc);
    @(posedge clk);
    #1;
    if (tv) begin
      expS  = W'(full);
      expC  = ((full >> W) & 1) != 0;
      expS2 = W2'(full2);
      expC2 = ((full2 >> W2) & 1) != 0;
    end
    expV = tv;
  endtask

  initial begin
    #2;
    checkOutput("resetInit");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        for (int c = 0; c < 2; c++) begin
          applyStimulus(W'(i), W'(j), 1'(c), 1'b1);
          checkOutput("exhaustive");
        end
      end
    end

    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
    checkOutput("rippleFF00");
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("allOnes");
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b1);
    checkOutput("altProp0");
    applyStimulus(8'hAA, 8'h55, 1'b1, 1'b1);
    checkOutput("altProp1");

    applyStimulus(8'd100, 8'd27, 1'b0, 1'b1);
    checkOutput("gateLoad");
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);
    checkOutput("gateIdle");
    applyStimulus('x, 'x, 1'bx, 1'b0);
    checkOutput("xIdle");

    // Reset asserted between edges must clear outputs without a clock edge.
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("preReset");
    #3;
    rst_n = 1'b0;
    #1;
    expS  = '0;
    expC  = 1'b0;
    expV  = 1'b0;
    expS2 = '0;
    expC2 = 1'b0;
    checkOutput("asyncReset");

    a        = 8'd50;
    b        = 8'd60;
    c0       = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetHold");
    rst_n = 1'b1;
    applyStimulus(8'd3, 8'd4, 1'b0, 1'b1);
    checkOutput("firstAfterRst");

    for (int n = 0; n < 20000; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      checkOutput("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
